emg_uart_streamer: RTL and testbench
====================================

Name: emg_uart_streamer

Overview:
- Outbound counterpart to the ADC capture path. The ADC port writes samples into RAM; this block takes samples the processor writes out and streams them off-chip.
- Snoops the processor's data-memory write bus. Captures 16-bit words stored to a reserved address into a FIFO.
- Serializes each word as two 8N1 UART bytes, high byte first.
- Exposes a status word that the top level muxes onto the processor's data-memory read path.

Parameters:
- TX_ADDR, 12'hFF0, word address that pushes a sample (data[15:0]).
- CLR_ADDR, 12'hFF1, word address whose write clears the sticky overflow flag (data ignored).
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
- FIFO_DEPTH, 16, sample entries; power of two.
- CNT_W, 5, count width; equals log2(FIFO_DEPTH)+1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wren  in  1  processor data-memory write enable.
- address_dmem  in  12  processor data-memory word address.
- data  in  32  processor store data.
- uart_tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in flight, START through the last STOP.
- overflow  out  1  sticky flag: a push was dropped.
- status  out  32  {23'b0, busy, overflow, full, empty, count[4:0]}.

Behaviour:
- Reset (reset=0, asynchronous):
  - uart_tx=1; busy=0; overflow=0; count=0; empty=1; full=0.
  - FIFO pointers=0; FSM=IDLE.
  - Reset mid-frame aborts the frame: line goes high immediately, FIFO contents are discarded.
- Push:
  - Occurs when wren=1 and address_dmem==TX_ADDR.
  - data[15:0] is written at the tail; count increments on the next edge.
  - If full and no pop in the same cycle: the word is dropped, overflow<=1, count unchanged.
  - Push and pop in the same cycle while full: the push is accepted and count is unchanged.
- Clear: wren=1 and address_dmem==CLR_ADDR sets overflow<=0. If a drop occurs in the same cycle, the set wins.
- Any other write address is ignored. wren=0 has no effect.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If !empty: pop the head into hold[15:0], set byte_sel=HI, go to START.
  - The first START cycle is the edge after the pop. busy rises with START.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA:
  - uart_tx = selected byte[bit_idx], LSB first.
  - Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - Selected byte is hold[15:8] when byte_sel=HI, hold[7:0] when byte_sel=LO.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then:
  - if byte_sel=HI: byte_sel=LO, go to START. No idle gap between the two bytes.
  - if byte_sel=LO: go to IDLE; busy falls.
- Back-to-back samples: one IDLE cycle (line high) between the LO stop bit and the next START.
- Timing:
  - One byte = 10*CLKS_PER_BIT cycles; one sample = 20*CLKS_PER_BIT cycles plus the 1-cycle IDLE gap.
  - Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit transition.
- Wrap-around: head and tail pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- All outputs are registered. status reflects register state after the most recent edge.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=16):
- Reset → uart_tx=1, status=32'h00000020, busy=0. Hold 100 cycles with no writes → line stays high.
- Single write data=32'hDEAD_A55A to 12'hFF0 → status count=1 for one cycle, then the pop.
  - Line carries start, 0xA5 LSB-first, stop, start, 0x5A LSB-first, stop: 80 cycles total.
  - busy falls after the 80th cycle.
- 17 consecutive writes (0x0000..0x0010) while idle:
  - first is popped immediately;
  - 16 fill the FIFO (full=1); no write is dropped, overflow=0.
  - An 18th write while full → overflow=1, its value never appears on the line.
  - Write to 12'hFF1 → overflow=0.
- Write to 12'hFF0 in the exact cycle a pop occurs while full → accepted, count stays 16, no overflow.
- Drain 20 samples across pointer wrap → bytes arrive in write order, each sample HI then LO, with a 1-cycle high gap between samples.
- Assert reset during the DATA state of the HI byte → uart_tx=1 asynchronously, status=32'h20. After release, no residual bits are sent.

Source files
------------

// File: rtl/emg_uart_streamer.sv
// Snoops data-memory writes to a reserved address, buffers the 16-bit samples in a FIFO and
// streams each one off-chip as two 8N1 UART bytes (high byte first).
module emg_uart_streamer #(
    parameter logic [11:0] TX_ADDR      = 12'hFF0,
    parameter logic [11:0] CLR_ADDR     = 12'hFF1,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    output logic        uart_tx,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] status
);

    localparam int unsigned PTR_W  = CNT_W - 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              byte_sel_q, byte_sel_d;  // 1: high byte, 0: low byte
    logic [15:0]       hold_q, hold_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              uart_tx_q, uart_tx_d;
    logic              busy_q, busy_d;
    logic [15:0]       mem_q [FIFO_DEPTH];

    logic       push, clr, pop, push_ok, drop, full, empty, baud_last;
    logic [7:0] tx_byte;
    logic       unused_data;

    assign unused_data = ^data[31:16];

    always_comb begin
        push       = wren && (address_dmem == TX_ADDR);
        clr        = wren && (address_dmem == CLR_ADDR);
        full       = (count_q == CNT_FULL);
        empty      = (count_q == '0);
        baud_last  = (baud_q == BAUD_LAST);
        pop        = 1'b0;
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        hold_d     = hold_q;

        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop        = 1'b1;
                    hold_d     = mem_q[head_q];
                    byte_sel_d = 1'b1;
                    baud_d     = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_sel_q) begin
                        byte_sel_d = 1'b0;
                        state_d    = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = push_ok ? tail_q + 1'b1 : tail_q;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr) begin
            overflow_d = 1'b0;
        end

        // Line value is computed from next state so the output can be registered.
        tx_byte = byte_sel_d ? hold_d[15:8] : hold_d[7:0];
        case (state_d)
            StStart: uart_tx_d = 1'b0;
            StData:  uart_tx_d = tx_byte[bit_idx_d];
            default: uart_tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_sel_q <= 1'b0;
            hold_q     <= 16'h0000;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            uart_tx_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            hold_q     <= hold_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            uart_tx_q  <= uart_tx_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[tail_q] <= data[15:0];
        end
    end

    assign uart_tx  = uart_tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign status   = {{(28 - CNT_W){1'b0}}, busy_q, overflow_q, full, empty, count_q};

endmodule

// File: tb/tb_emg_uart_streamer.sv
// Bench for emg_uart_streamer: a sample-queue model predicts the serial line and status word
// every cycle; directed steps cover reset, fill/overflow, push-during-pop, wrap and mid-frame reset.
module tb_emg_uart_streamer;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 20 * CPB;
    localparam logic [11:0] TX  = 12'hFF0;
    localparam logic [11:0] CLR = 12'hFF1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren = 1'b0;
    logic [11:0] address_dmem = 12'h000;
    logic [31:0] data = 32'h0;
    logic        uart_tx, busy, overflow;
    logic [31:0] status;

    int compared = 0;
    int mismatched = 0;

    // Model: samples waiting in the FIFO, sample on the wire, busy cycles left, sticky flag.
    logic [15:0] q[$];
    logic [15:0] cur = 16'h0;
    int          left = 0;
    logic        ovf = 1'b0;

    emg_uart_streamer #(
        .TX_ADDR     (TX),
        .CLR_ADDR    (CLR),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wren        (wren),
        .address_dmem(address_dmem),
        .data        (data),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .overflow    (overflow),
        .status      (status)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic push, clr, full, pop, drop;
        push = wren && (address_dmem == TX);
        clr  = wren && (address_dmem == CLR);
        full = (q.size() == DEPTH);
        pop  = (left == 0) && (q.size() > 0);
        if (pop) begin
            cur  = q.pop_front();
            left = FRAME;
        end else if (left > 0) begin
            left--;
        end
        drop = push && full && !pop;
        if (push && !drop) q.push_back(data[15:0]);
        if (drop) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
    endtask

    // Frame of a sample: start, 8 data LSB first, stop for the high byte, then the same for low.
    function automatic logic model_line();
        int k, j, s;
        logic [7:0] b;
        if (left == 0) return 1'b1;
        k = FRAME - left;
        b = (k < 10 * CPB) ? cur[15:8] : cur[7:0];
        j = k % (10 * CPB);
        s = j / CPB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s-1];
    endfunction

    function automatic logic [31:0] model_status();
        int cnt;
        logic [31:0] s;
        cnt  = q.size();
        s    = '0;
        s[4:0] = 5'(cnt);
        s[5] = (cnt == 0);
        s[6] = (cnt == DEPTH);
        s[7] = ovf;
        s[8] = (left > 0);
        return s;
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("line", 32'(uart_tx), 32'(model_line()));
        chk("status", status, model_status());
        chk("busy", 32'(busy), 32'(left > 0));
        chk("overflow", 32'(overflow), 32'(ovf));
    endtask

    task automatic write(input logic [11:0] a, input logic [31:0] d);
        wren = 1'b1;
        address_dmem = a;
        data = d;
        step();
        wren = 1'b0;
        address_dmem = 12'h000;
        data = $urandom;
    endtask

    function automatic logic [11:0] other_addr();
        logic [11:0] a;
        do a = 12'($urandom); while (a == TX || a == CLR);
        return a;
    endfunction

    initial begin
        int n;
        int pushes;

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_line", 32'(uart_tx), 32'd1);
        chk("rst_status", status, 32'h0000_0020);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (100) step();

        // Single sample 0xA55A
        write(TX, 32'hDEAD_A55A);
        chk("single_count", 32'(status[4:0]), 32'd1);
        step();
        chk("single_start", 32'(uart_tx), 32'd0);
        repeat (FRAME + 4) step();
        chk("single_done", status, 32'h0000_0020);

        // Fill: first popped at once, 16 fill the FIFO
        for (int i = 0; i < 17; i++) write(TX, {16'($urandom), 16'(i)});
        chk("fill_full", 32'(status[6]), 32'd1);
        chk("fill_count", 32'(status[4:0]), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd0);
        write(other_addr(), $urandom);
        write(TX, $urandom);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_count", 32'(status[4:0]), 32'd16);
        write(other_addr(), $urandom);
        write(CLR, $urandom);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Push on the very edge that pops from a full FIFO
        n = 0;
        while (!(left == 0 && q.size() == DEPTH) && n < 500) begin
            step();
            n++;
        end
        write(TX, $urandom);
        chk("pushpop_count", 32'(status[4:0]), 32'd16);
        chk("pushpop_ovf", 32'(overflow), 32'd0);

        // Drain 20 samples with 4 extra pushes, so pointers wrap
        pushes = 0;
        n = 0;
        while ((pushes < 4 || left > 0 || q.size() > 0) && n < 3000) begin
            if (pushes < 4 && q.size() < DEPTH && $urandom_range(0, 7) == 0) begin
                write(TX, $urandom);
                pushes++;
            end else if ($urandom_range(0, 15) == 0) begin
                write(other_addr(), $urandom);
            end else begin
                step();
            end
            n++;
        end
        step();
        chk("drain_status", status, 32'h0000_0020);

        // Reset while the high byte (0x00) is in its data bits
        write(TX, {16'($urandom), 8'h00, 8'($urandom)});
        n = 0;
        while (left != 60 && n < 200) begin
            step();
            n++;
        end
        chk("pre_rst_line", 32'(uart_tx), 32'd0);
        #3 reset = 1'b0;
        #1;
        chk("midrst_line", 32'(uart_tx), 32'd1);
        chk("midrst_status", status, 32'h0000_0020);
        q.delete();
        left = 0;
        ovf = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (100) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
